// File: rtl/mfm_write_encoder.sv
// MFM write encoder: byte-wide valid/ready input, serial MFM flux-pulse output, MSB first.
// Latency: word accepted at edge E in IDLE -> LOAD at E+1 -> first half-cell on mfm_out from E+2.
// Backpressure: in_ready = ~hold_full; a word queued behind the one in flight follows back-to-back.
module mfm_write_encoder #(
  parameter int HALF_CELL_CLKS = 5,
  parameter int PULSE_CLKS     = 2,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mfm_out,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = (HALF_CELL_CLKS > 1) ? $clog2(HALF_CELL_CLKS) : 1;
  localparam int HW = $clog2(2 * DATA_W);
  localparam int IW = HW - 1;

  localparam logic [CW-1:0] LAST_CNT  = CW'(HALF_CELL_CLKS - 1);
  localparam logic [CW-1:0] PULSE_CNT = CW'(PULSE_CLKS);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);
  localparam logic [IW-1:0] MSB_IDX   = IW'(DATA_W - 1);
  localparam logic [IW-1:0] SYNC_IDX  = IW'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_sync_q, hold_sync_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_data_q, shift_data_d;
  logic              shift_sync_q, shift_sync_d;
  logic              prev_bit_q, prev_bit_d;
  logic [HW-1:0]     half_q, half_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mfm_out_q, mfm_out_d;
  logic              underrun_q, underrun_d;

  logic take_hold;
  logic xfer;

  // MFM bit carried by half-cell h of word w: even half-cells are clock bits, odd ones data bits.
  // p is the last data bit of the preceding word (0 after IDLE).
  function automatic logic mfm_bit(input logic [DATA_W-1:0] w, input logic s,
                                   input logic p, input logic [HW-1:0] h);
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] prevs;
    logic              d;
    logic              pb;
    idx   = MSB_IDX - h[HW-1:1];
    prevs = {p, w[DATA_W-1:1]};
    d     = w[idx];
    pb    = prevs[idx];
    if (h[0]) begin
      return d;
    end
    return ~pb & ~d & ~(s & (idx == SYNC_IDX));
  endfunction

  assign xfer = in_valid & ~hold_full_q;

  // Next-state, counters, holding register and the pulse value for the coming cycle.
  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_sync_d  = hold_sync_q;
    hold_full_d  = hold_full_q;
    shift_data_d = shift_data_q;
    shift_sync_d = shift_sync_q;
    prev_bit_d   = prev_bit_q;
    half_d       = half_q;
    cnt_d        = cnt_q;
    mfm_out_d    = 1'b0;
    underrun_d   = 1'b0;
    take_hold    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        prev_bit_d = 1'b0;
        if (enable && hold_full_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_data_d = hold_data_q;
        shift_sync_d = hold_sync_q;
        take_hold    = 1'b1;
        half_d       = '0;
        cnt_d        = '0;
        state_d      = ST_SHIFT;
        mfm_out_d    = mfm_bit(hold_data_q, hold_sync_q, prev_bit_q, '0) & ('0 < PULSE_CNT);
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d     = cnt_q + 1'b1;
          mfm_out_d = mfm_bit(shift_data_q, shift_sync_q, prev_bit_q, half_q) & (cnt_d < PULSE_CNT);
        end else if (half_q != LAST_HALF) begin
          cnt_d     = '0;
          half_d    = half_q + 1'b1;
          mfm_out_d = mfm_bit(shift_data_q, shift_sync_q, prev_bit_q, half_d);
        end else if (enable && hold_full_q) begin
          // Seamless reload: the next word's first half-cell follows without a gap.
          shift_data_d = hold_data_q;
          shift_sync_d = hold_sync_q;
          take_hold    = 1'b1;
          prev_bit_d   = shift_data_q[0];
          cnt_d        = '0;
          half_d       = '0;
          mfm_out_d    = mfm_bit(hold_data_q, hold_sync_q, shift_data_q[0], '0);
        end else begin
          state_d    = ST_IDLE;
          prev_bit_d = 1'b0;
          underrun_d = enable;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Consuming and refilling the holding register at the same edge keeps the new word.
    if (take_hold) begin
      hold_full_d = 1'b0;
    end
    if (xfer) begin
      hold_data_d = in_data;
      hold_sync_d = in_sync;
      hold_full_d = 1'b1;
    end
  end

  // State register with synchronous reset; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_data_q  <= '0;
      hold_sync_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_data_q <= '0;
      shift_sync_q <= 1'b0;
      prev_bit_q   <= 1'b0;
      half_q       <= '0;
      cnt_q        <= '0;
      mfm_out_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_sync_q  <= hold_sync_d;
      hold_full_q  <= hold_full_d;
      shift_data_q <= shift_data_d;
      shift_sync_q <= shift_sync_d;
      prev_bit_q   <= prev_bit_d;
      half_q       <= half_d;
      cnt_q        <= cnt_d;
      mfm_out_q    <= mfm_out_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready = ~hold_full_q;
  assign busy     = (state_q == ST_SHIFT);
  assign mfm_out  = mfm_out_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Bench for mfm_write_encoder: table of single words, hand-written corner sequences,
// and random back-to-back bursts checked against a bit-level MFM reference model.
module tb_mfm_write_encoder;

  localparam int HC        = 5;
  localparam int PW        = 2;
  localparam int DW        = 8;
  localparam int CWD       = 2 * DW;
  localparam int WORD_CLKS = CWD * HC;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [DW-1:0] in_data;
  logic          in_sync;
  logic          in_valid;
  logic          in_ready;
  logic          mfm_out;
  logic          busy;
  logic          underrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0]  data;
    logic           sync;
    logic [CWD-1:0] exp;
  } vec_t;

  vec_t          vecs[6];
  logic [DW-1:0] rnd_d[4];
  logic          rnd_s[4];
  int            rnd_len;

  mfm_write_encoder #(
    .HALF_CELL_CLKS(HC),
    .PULSE_CLKS    (PW),
    .DATA_W        (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .in_data (in_data),
    .in_sync (in_sync),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mfm_out (mfm_out),
    .busy    (busy),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // MFM code of one word: for each data bit MSB first emit {clock, data}, where
  // clock is 1 only between two zero bits, and the sync flag drops the clock of bit 2.
  function automatic logic [CWD-1:0] ref_code(input logic [DW-1:0] d, input logic s, input logic p);
    logic [CWD-1:0] c;
    logic           prev;
    logic           cb;
    c    = '0;
    prev = p;
    for (int i = DW - 1; i >= 0; i--) begin
      cb = !prev && !d[i];
      if (s && i == 2) cb = 1'b0;
      c    = {c[CWD-3:0], cb, d[i]};
      prev = d[i];
    end
    return c;
  endfunction

  // Entered and left on a falling edge; the transfer happens at the rising edge in between.
  task automatic send(input logic [DW-1:0] d, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_start"}, 32'(busy), 32'd1);
  endtask

  // Samples one full word of pulses starting at the current falling edge.
  task automatic capture(input logic [CWD-1:0] exp, input string name);
    logic [CWD-1:0] got;
    int             bad;
    logic           e;
    got = '0;
    bad = 0;
    for (int k = 0; k < WORD_CLKS; k++) begin
      e = exp[CWD-1-k/HC] && ((k % HC) < PW);
      if ((k % HC) == 0) got[CWD-1-k/HC] = mfm_out;
      if (mfm_out !== e) bad++;
      if (busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk({name, "_code"}, 32'(got), 32'(exp));
    chk({name, "_shape"}, 32'(bad), 32'd0);
  endtask

  task automatic check_end(input string name, input logic exp_underrun);
    chk({name, "_underrun"}, 32'(underrun), 32'(exp_underrun));
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_mfm0"}, 32'(mfm_out), 32'd0);
    @(negedge clk);
    chk({name, "_underrun_clr"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b0, 16'hAAAA};
    vecs[1] = '{8'hA1, 1'b0, 16'h44A9};
    vecs[2] = '{8'hA1, 1'b1, 16'h4489};
    vecs[3] = '{8'hFF, 1'b0, 16'h5555};
    vecs[4] = '{8'h0F, 1'b0, 16'hAA55};
    vecs[5] = '{8'h80, 1'b0, 16'h4AAA};

    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_sync  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mfm", 32'(mfm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // First-word latency: accept at E, LOAD at E+1, first pulse from E+2.
    send(8'h00, 1'b0);
    chk("lat_e1_busy", 32'(busy), 32'd0);
    chk("lat_e1_mfm", 32'(mfm_out), 32'd0);
    @(negedge clk);
    chk("lat_load_busy", 32'(busy), 32'd0);
    chk("lat_load_mfm", 32'(mfm_out), 32'd0);
    @(negedge clk);
    chk("lat_e2_busy", 32'(busy), 32'd1);
    chk("lat_e2_mfm", 32'(mfm_out), 32'd1);
    chk("lat_e2_in_ready", 32'(in_ready), 32'd1);
    capture(16'hAAAA, "lat");
    check_end("lat", 1'b1);

    // Isolated words, each ending in an underrun.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].sync);
      wait_busy("vec");
      capture(vecs[i].exp, $sformatf("vec%0d", i));
      check_end($sformatf("vec%0d", i), 1'b1);
    end

    // Back-to-back 0xFF then 0x00: prev_bit carries over, no gap cycle.
    fork
      begin
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
      end
      begin
        wait_busy("b2b");
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        capture(16'h5555, "b2b_w0");
        capture(16'h2AAA, "b2b_w1");
      end
    join
    check_end("b2b", 1'b1);

    // enable dropped mid-word: word completes, no underrun, queued word stays held.
    fork
      begin
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        repeat (40) @(negedge clk);
        enable = 1'b0;
      end
      begin
        wait_busy("dis");
        capture(16'hAAAA, "dis_w0");
      end
    join
    chk("dis_underrun", 32'(underrun), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_in_ready", 32'(in_ready), 32'd0);
    chk("dis_mfm", 32'(mfm_out), 32'd0);
    repeat (20) @(negedge clk);
    chk("dis_still_idle", 32'(busy), 32'd0);
    chk("dis_still_held", 32'(in_ready), 32'd0);
    enable = 1'b1;
    wait_busy("dis_resume");
    capture(16'hAA55, "dis_w1");
    check_end("dis", 1'b1);

    // Reset in half-cell 7 with a word queued: everything is dropped.
    send(8'h00, 1'b0);
    wait_busy("rstmid");
    send(8'h0F, 1'b0);
    repeat (7 * HC) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_mfm", 32'(mfm_out), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_no_resume", 32'(busy), 32'd0);
    send(8'h00, 1'b0);
    wait_busy("rstmid_resend");
    capture(16'hAAAA, "rstmid_resend");
    check_end("rstmid", 1'b1);

    // Random bursts of back-to-back words against the reference model.
    for (int b = 0; b < 6; b++) begin
      rnd_len = $urandom_range(1, 4);
      for (int i = 0; i < rnd_len; i++) begin
        rnd_d[i] = DW'($urandom_range(0, 255));
        rnd_s[i] = ($urandom_range(0, 3) == 0);
      end
      fork
        begin
          for (int i = 0; i < rnd_len; i++) send(rnd_d[i], rnd_s[i]);
        end
        begin
          logic p;
          p = 1'b0;
          wait_busy("rnd");
          for (int i = 0; i < rnd_len; i++) begin
            capture(ref_code(rnd_d[i], rnd_s[i], p), $sformatf("rnd%0d_%0d", b, i));
            p = rnd_d[i][0];
          end
        end
      join
      check_end($sformatf("rnd%0d", b), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
